add16_seq_ctrl: RTL and testbench
=================================

Name: add16_seq_ctrl

Overview:
- Multi-precision add/subtract sequencer built around one shared add16bits instance (a, b, carry_in -> sum, carry_out).
- Adds or subtracts two 16*WORDS-bit operands over WORDS clock cycles, one 16-bit word per cycle, least significant word first.
- The carry is registered between words.
- Provides the ALU layer with wide arithmetic without replicating adders; start/ready/done handshake toward the issuing control logic.

Parameters:
- WORDS, 4, number of 16-bit words per operand (>=1); operand width W = 16*WORDS.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only on an edge where ready=1
- sub  input  1  0 = A+B+carry_in, 1 = A-B (B inverted, initial carry forced to 1)
- carry_in  input  1  initial carry for add; ignored when sub=1
- op_a  input  W  operand A
- op_b  input  W  operand B
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, result valid
- result  output  W  sum/difference, held until next accepted start
- carry_out  output  1  adder carry from final word (sub: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow of the full-width operation

Behaviour:
- Reset (rst_n=0 at a rising edge, any state, including mid-RUN):
  - state=IDLE, word index=0, carry reg=0.
  - result=0, carry_out=0, overflow=0, done=0, busy=0, ready=1.
  - An interrupted operation is discarded; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch op_a, op_b, sub.
  - Carry reg = sub ? 1 : carry_in.
  - Index=0; result, carry_out and overflow cleared to 0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Adder inputs: a = A word[idx], b = sub ? ~B word[idx] : B word[idx], carry_in = carry reg.
  - result[16*idx +: 16] <= sum; carry reg <= adder carry_out; idx <= idx+1.
  - On the edge processing idx=WORDS-1:
    - carry_out <= adder carry_out.
    - overflow <= (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff_msb is the msb after any inversion.
    - Go to DONE.
- Latency:
  - RUN lasts exactly WORDS cycles (edges k+1 .. k+WORDS).
  - done=1 during the cycle after edge k+WORDS, i.e. WORDS+1 edges after the start edge counting the start edge.
- DONE: done=1, ready=0; the next edge goes to IDLE with done=0. Outputs hold.
- Ignored inputs:
  - start while RUN or DONE has no effect and is not queued.
  - Changes on op_a/op_b/sub/carry_in after acceptance do not affect the operation.
- result bits of words not yet processed read 0 during RUN; only the value at done is architecturally valid.
- Word index counter is ceil(log2(WORDS)) bits, minimum 1 bit.
- WORDS=1: a single RUN cycle.
- No wrap of the index beyond WORDS-1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> ready=1, busy=0, done=0, result=0, carry_out=0, overflow=0.
- Add with word carry (WORDS=4): op_a=0x0000_0000_0000_FFFF, op_b=0x1, carry_in=0, sub=0, start -> busy for 4 cycles, single done pulse exactly 4 cycles after the start edge, result=0x0000_0000_0001_0000, carry_out=0, overflow=0.
- Full carry chain: op_a=op_b=0xFFFF_FFFF_FFFF_FFFF, carry_in=1 -> result=0xFFFF_FFFF_FFFF_FFFF, carry_out=1, overflow=0. Signed overflow: op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=1, carry_in=0 -> result=0x8000_0000_0000_0000, carry_out=0, overflow=1.
- Subtract: sub=1, op_a=5, op_b=7, carry_in=1 (must be ignored) -> result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0 (borrow), overflow=0. Then op_a=7, op_b=5 -> result=2, carry_out=1.
- Busy protection: after start, change op_a/op_b and pulse start during RUN and DONE -> result matches the originally latched operands, exactly one done, ready returns 1 the cycle after done.
- Reset mid-operation: rst_n=0 on the 2nd RUN edge -> IDLE with all outputs zero, no done. New start with op_a=3, op_b=4 -> result=7 and done after 4 cycles.

Source files
------------

// File: rtl/add16_seq_ctrl_if.sv
// add16_seq_ctrl_if: start/ready/done handshake and operand/result bus of the
// multi-precision add/subtract sequencer.  Revision 1.0.
`default_nettype none

interface add16_seq_ctrl_if #(
   parameter int WORDS = 4
);
   localparam int W = 16 * WORDS;

   logic         start;
   logic         sub;
   logic         carry_in;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   modport master (
      output start, sub, carry_in, op_a, op_b,
      input  ready, busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, sub, carry_in, op_a, op_b,
      output ready, busy, done, result, carry_out, overflow
   );
endinterface

`default_nettype wire

// File: rtl/add16_seq_ctrl.sv
// add16_seq_ctrl: WORDS x 16-bit add/subtract sequenced through one shared
// 16-bit adder, least significant word first.  Revision 1.0.
`default_nettype none

module add16bits (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carry_in,
   output logic [15:0] sum,
   output logic        carry_out
);
   assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {16'b0, carry_in};
endmodule

module add16_seq_ctrl #(
   parameter int WORDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   add16_seq_ctrl_if.slave   bus
);
   localparam int W     = 16 * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic             carry_q,  carry_d;
   logic [W-1:0]     a_q,      a_d;
   logic [W-1:0]     b_q,      b_d;
   logic             sub_q,    sub_d;
   logic [W-1:0]     result_q, result_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;

   logic [IDX_W+3:0] word_base;
   logic [15:0]      a_word;
   logic [15:0]      b_eff;
   logic [15:0]      add_sum;
   logic             add_cout;
   logic             last_word;

   assign word_base = {idx_q, 4'b0000};
   assign a_word    = a_q[word_base +: 16];
   // Subtraction is A + ~B + 1; the +1 comes from the carry seeded at start.
   assign b_eff     = sub_q ? ~b_q[word_base +: 16] : b_q[word_base +: 16];
   assign last_word = (idx_q == IDX_W'(WORDS - 1));

   add16bits u_add (
      .a         (a_word),
      .b         (b_eff),
      .carry_in  (carry_q),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d      = bus.op_a;
               b_d      = bus.op_b;
               sub_d    = bus.sub;
               carry_d  = bus.sub ? 1'b1 : bus.carry_in;
               idx_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[word_base +: 16] = add_sum;
            carry_d = add_cout;
            if (last_word) begin
               cout_d  = add_cout;
               ovf_d   = (a_word[15] == b_eff[15]) && (add_sum[15] != a_word[15]);
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.ready     = (state_q == ST_IDLE);
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_add16_seq_ctrl.sv
// tb_add16_seq_ctrl: scoreboard bench for add16_seq_ctrl (WORDS=4).
`default_nettype none

module tb_add16_seq_ctrl;
   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   typedef struct packed {
      logic [W-1:0] result;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   err_cnt;
   int   chk_cnt;
   int   done_cnt;
   exp_t sb_q[$];
   exp_t last_exp;

   add16_seq_ctrl_if #(.WORDS(WORDS)) bus ();

   add16_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input logic ci);
      logic [W-1:0] be;
      logic [W:0]   t;
      exp_t         e;
      be       = s ? ~b : b;
      t        = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
      e.result = t[W-1:0];
      e.cout   = t[W];
      e.ovf    = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
      return e;
   endfunction

   // Scoreboard: every done pops one expected result.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         exp_t e;
         done_cnt++;
         if (sb_q.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("result", bus.result, e.result);
            check("carry_out", W'(bus.carry_out), W'(e.cout));
            check("overflow", W'(bus.overflow), W'(e.ovf));
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci, input bit disturb);
      int  cyc;
      bit  seen;
      @(negedge clk);
      bus.op_a = a; bus.op_b = b; bus.sub = s; bus.carry_in = ci; bus.start = 1'b1;
      last_exp = model(a, b, s, ci);
      sb_q.push_back(last_exp);
      @(posedge clk); #1;
      bus.start = disturb;
      seen = 1'b0;
      for (cyc = 1; cyc <= 10; cyc++) begin
         if (disturb) begin
            bus.op_a = ~a; bus.op_b = a ^ b; bus.sub = ~s; bus.carry_in = ~ci;
         end
         @(posedge clk); #1;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         check("busy_in_run", W'(bus.busy), 1);
      end
      if (!seen) check("done_timeout", 0, 1);
      check("done_latency", W'(cyc), W'(WORDS));
      check("ready_in_done", W'(bus.ready), 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("ready_after_done", W'(bus.ready), 1);
      check("done_one_cycle", W'(bus.done), 0);
      check("result_held", bus.result, last_exp.result);
      if (disturb) begin
         @(posedge clk); #1;
         check("no_queued_start", W'(bus.busy), 0);
      end
   endtask

   initial begin
      err_cnt = 0; chk_cnt = 0; done_cnt = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.sub = 1'b0; bus.carry_in = 1'b0;
      bus.op_a = '0; bus.op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", W'(bus.ready), 1);
      check("rst_busy", W'(bus.busy), 0);
      check("rst_done", W'(bus.done), 0);
      check("rst_result", bus.result, 0);
      check("rst_cout", W'(bus.carry_out), 0);
      check("rst_ovf", W'(bus.overflow), 0);
      rst_n = 1'b1;

      run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
      run_op(64'd5, 64'd7, 1'b1, 1'b1, 1'b0);
      run_op(64'd7, 64'd5, 1'b1, 1'b0, 1'b0);
      run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b0);
      run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
         run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'(i), 1'($urandom), 1'b0);

      // Reset on the second RUN edge discards the operation.
      @(negedge clk);
      bus.op_a = 64'd100; bus.op_b = 64'd200; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_ready", W'(bus.ready), 1);
      check("midrst_busy", W'(bus.busy), 0);
      check("midrst_result", bus.result, 0);
      check("midrst_cout", W'(bus.carry_out), 0);
      repeat (6) @(posedge clk);
      #1;
      check("midrst_no_done", W'(bus.done), 0);

      run_op(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
      check("final_result", bus.result, 64'd7);

      repeat (3) @(posedge clk);
      check("done_count", W'(done_cnt), 12);
      check("sb_drained", W'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
